// File: rtl/lfsr_pkg.sv
// Shared constants and pure helpers for the 8-bit Fibonacci LFSR.
// The RTL imports these, and so can a reference model.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;
  localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 8'hB8;

  function automatic logic [LFSR_W-1:0] bit_reverse(input logic [LFSR_W-1:0] value);
    logic [LFSR_W-1:0] result;
    result = '0;
    for (int i = 0; i < LFSR_W; i++) begin
      result[i] = value[LFSR_W-1-i];
    end
    return result;
  endfunction

  // Shift left and insert the XOR of the tapped bits at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] state,
                                                  input logic [LFSR_W-1:0] taps);
    return {state[LFSR_W-2:0], ^(state & taps)};
  endfunction

  // An all-zero seed would lock the register up, so it falls back to the default seed.
  function automatic logic [LFSR_W-1:0] safe_seed(input logic [LFSR_W-1:0] seed);
    return (seed == '0) ? DEFAULT_SEED : seed;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with feedback and recovery from the all-zero lockup state.
// The next-state value is also exported so the top can register a derived view in step.
module lfsr_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
  parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state
);

  localparam logic [LFSR_W-1:0] SEED_EFF = safe_seed(SEED);

  logic [LFSR_W-1:0] lfsr_p0;

  always_comb begin
    next_state = lfsr_next(lfsr_p0, TAPS);
    // An all-zero state is a fixed point of the feedback, so reload the seed instead.
    if (lfsr_p0 == '0) begin
      next_state = SEED_EFF;
    end
  end

  // stage p0: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_p0 <= SEED_EFF;
    end else begin
      lfsr_p0 <= next_state;
    end
  end

  assign state = lfsr_p0;

endmodule

// File: rtl/lfsr_8bit.sv
// Free-running 8-bit maximal-length LFSR. Exposes the raw state and a
// bit-reversed view of it; both are registered on the same edge.
module lfsr_8bit
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
  parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] lfsr,
  output logic [LFSR_W-1:0] random_num
);

  localparam logic [LFSR_W-1:0] SEED_REV = bit_reverse(safe_seed(SEED));

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] next_state;
  logic [LFSR_W-1:0] rand_p0;

  lfsr_core #(
    .SEED(SEED),
    .TAPS(TAPS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .next_state(next_state)
  );

  // stage p0: reversed view, built from the same next state so it never lags lfsr
  always_ff @(posedge clk) begin
    if (!rst) begin
      rand_p0 <= SEED_REV;
    end else begin
      rand_p0 <= bit_reverse(next_state);
    end
  end

  assign lfsr       = state;
  assign random_num = rand_p0;

endmodule

// File: tb/tb_lfsr_8bit.sv
// Directed bench for lfsr_8bit: reset, the known start of the sequence, full period,
// mid-run reset, reset pulses between edges, and recovery from a forced zero state.
module tb_lfsr_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] lfsr;
  logic [7:0] random_num;

  int total;
  int bad;

  logic [7:0] exp_lfsr [8];
  logic [7:0] exp_rand [8];

  lfsr_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .lfsr      (lfsr),
    .random_num(random_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pair(input string name, input logic [7:0] want_l, input logic [7:0] want_r);
    total++;
    if (lfsr !== want_l) begin
      bad++;
      $display("FAIL %s lfsr: got %h want %h", name, lfsr, want_l);
    end
    total++;
    if (random_num !== want_r) begin
      bad++;
      $display("FAIL %s random_num: got %h want %h", name, random_num, want_r);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    check_pair("reset", 8'h01, 8'h80);
  endtask

  task automatic test_sequence();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_pair($sformatf("seq[%0d]", i), exp_lfsr[i], exp_rand[i]);
    end
  endtask

  task automatic test_period();
    bit seen [256];
    int bad_zero, bad_dup, bad_rev, bad_early;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    do_reset();
    seen[8'h01] = 1'b1;
    bad_zero = 0; bad_dup = 0; bad_rev = 0; bad_early = 0;
    for (int k = 1; k <= 254; k++) begin
      step();
      if (lfsr === 8'h00) bad_zero++;
      if (lfsr === 8'h01) bad_early++;
      if (seen[lfsr]) bad_dup++;
      seen[lfsr] = 1'b1;
      if (random_num !== rev8(lfsr)) bad_rev++;
    end
    step();
    total++;
    if (lfsr !== 8'h01) begin
      bad++;
      $display("FAIL period_return: got %h want 01 at step 255", lfsr);
    end
    total++;
    if (random_num !== 8'h80) begin
      bad++;
      $display("FAIL period_return_rand: got %h want 80", random_num);
    end
    total++;
    if (bad_zero != 0) begin
      bad++;
      $display("FAIL period_zero: zero seen %0d times want 0", bad_zero);
    end
    total++;
    if (bad_early != 0 || bad_dup != 0) begin
      bad++;
      $display("FAIL period_unique: early=%0d dup=%0d want 0/0", bad_early, bad_dup);
    end
    total++;
    if (bad_rev != 0) begin
      bad++;
      $display("FAIL period_reverse: %0d cycles with random_num != reverse(lfsr) want 0", bad_rev);
    end
    for (int v = 1; v < 256; v++) begin
      total++;
      if (!seen[v]) begin
        bad++;
        $display("FAIL period_cover: value %h never seen", v[7:0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (10) step();
    rst = 1'b0;
    step();
    check_pair("mid_reset", 8'h01, 8'h80);
    rst = 1'b1;
    step();
    check_pair("mid_reset_restart", 8'h02, 8'h40);
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (3) step();
    check_pair("glitch_pre", 8'h08, 8'h10);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    check_pair("glitch_hold", 8'h08, 8'h10);
    step();
    check_pair("glitch_next", 8'h11, 8'h88);
  endtask

  task automatic test_lockup();
    do_reset();
    repeat (5) step();
    force dut.u_core.lfsr_p0 = 8'h00;
    #1;
    release dut.u_core.lfsr_p0;
    #1;
    total++;
    if (lfsr !== 8'h00) begin
      bad++;
      $display("FAIL lockup_forced: got %h want 00", lfsr);
    end
    step();
    check_pair("lockup_recover", 8'h01, 8'h80);
    step();
    check_pair("lockup_resume", 8'h02, 8'h40);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    exp_lfsr = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};
    exp_rand = '{8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2, 8'h71, 8'h38};
    test_reset();
    test_sequence();
    test_period();
    test_mid_reset();
    test_glitch();
    test_lockup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
